// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronizes and debounces a raw button, then emits
// count-up strobes on press and auto-repeat while held, plus a release strobe.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES     = 500000,
  parameter int unsigned REPEAT_DELAY_CYCLES = 25000000,
  parameter int unsigned REPEAT_RATE_CYCLES  = 5000000,
  parameter int unsigned REPEAT_EN           = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_pulse,
  output logic o_pressed,
  output logic o_release,
  output logic o_repeating
);

  localparam int unsigned MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY_CYCLES) ?
                                   DEBOUNCE_CYCLES : REPEAT_DELAY_CYCLES;
  localparam int unsigned MAX_P  = (MAX_AB > REPEAT_RATE_CYCLES) ? MAX_AB : REPEAT_RATE_CYCLES;
  localparam int unsigned CNT_W  = $clog2(MAX_P);

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic             RPT_ON     = (REPEAT_EN != 0);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DEB,
    HELD,
    REPEAT,
    RELEASE_DEB
  } state_e;

  logic [1:0]       sync_q;
  logic             btn_s;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pulse_ev_q;
  logic             release_ev_q;

  assign btn_s = sync_q[1];

  // Two-flop synchronizer; btn_s is the only view of the button downstream.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], i_btn};
    end
  end

  // Debounce / repeat FSM sharing one cycle counter; strobes are raised as events
  // on the transition edge and re-timed by the output stage below.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pulse_ev_q   <= 1'b0;
      release_ev_q <= 1'b0;
    end else begin
      pulse_ev_q   <= 1'b0;
      release_ev_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (btn_s) begin
            state_q <= PRESS_DEB;
            cnt_q   <= CNT_ONE;
          end
        end
        PRESS_DEB: begin
          if (!btn_s) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == DEB_LAST) begin
            state_q    <= HELD;
            cnt_q      <= '0;
            pulse_ev_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        HELD: begin
          if (!btn_s) begin
            state_q <= RELEASE_DEB;
            cnt_q   <= CNT_ONE;
          end else if (RPT_ON && (cnt_q == DELAY_LAST)) begin
            state_q    <= REPEAT;
            cnt_q      <= '0;
            pulse_ev_q <= 1'b1;
          end else if (cnt_q != DELAY_LAST) begin
            // Holds at DELAY_LAST when auto-repeat is off, so it never wraps.
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        REPEAT: begin
          if (!btn_s) begin
            state_q <= RELEASE_DEB;
            cnt_q   <= CNT_ONE;
          end else if (cnt_q == RATE_LAST) begin
            cnt_q      <= '0;
            pulse_ev_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        RELEASE_DEB: begin
          if (btn_s) begin
            // A bounce back to pressed restarts the repeat delay without a strobe.
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q == DEB_LAST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            release_ev_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Registered outputs, one cycle behind the state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_pulse     <= 1'b0;
      o_pressed   <= 1'b0;
      o_release   <= 1'b0;
      o_repeating <= 1'b0;
    end else begin
      o_pulse     <= pulse_ev_q;
      o_release   <= release_ev_q;
      o_pressed   <= (state_q == HELD) || (state_q == REPEAT) || (state_q == RELEASE_DEB);
      o_repeating <= (state_q == REPEAT);
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: stimulus queues expected strobe
// cycles, a negedge monitor pops and compares whenever a strobe appears.
module tb_button_conditioner;

  logic clk;
  logic rst;
  logic btn_a, btn_b;
  logic a_pulse, a_pressed, a_release, a_repeating;
  logic b_pulse, b_pressed, b_release, b_repeating;

  typedef struct {
    bit rel;
    int at;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   prev_pulse_a = 0;
  bit   prev_pulse_b = 0;
  bit   b_rep_seen = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY_CYCLES(10), .REPEAT_RATE_CYCLES(3), .REPEAT_EN(1)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .i_btn(btn_a),
    .o_pulse(a_pulse), .o_pressed(a_pressed), .o_release(a_release), .o_repeating(a_repeating)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY_CYCLES(10), .REPEAT_RATE_CYCLES(3), .REPEAT_EN(0)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_btn(btn_b),
    .o_pulse(b_pulse), .o_pressed(b_pressed), .o_release(b_release), .o_repeating(b_repeating)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int d, input bit rel, input int at);
    exp_t e;
    e.rel = rel;
    e.at  = at;
    if (d == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  task automatic mon_evt(input int d, input bit rel);
    exp_t e;
    bit   have;
    have = 0;
    if (d == 0 && qa.size() > 0) begin e = qa.pop_front(); have = 1; end
    if (d == 1 && qb.size() > 0) begin e = qb.pop_front(); have = 1; end
    checks++;
    if (!have) begin
      failures++;
      $display("FAIL dut%0d unexpected %s at cycle %0d (none queued)", d, rel ? "release" : "pulse", cyc);
    end else if (e.rel != rel || e.at != cyc) begin
      failures++;
      $display("FAIL dut%0d event: got %s at cycle %0d, expected %s at cycle %0d",
               d, rel ? "release" : "pulse", cyc, e.rel ? "release" : "pulse", e.at);
    end
  endtask

  task automatic mon_excl(input int d, input logic pulse, input logic release_s, input bit prev);
    checks++;
    if (release_s || prev) begin
      failures++;
      $display("FAIL dut%0d pulse_excl at cycle %0d: release=%0b prev_pulse=%0b, required 0/0",
               d, cyc, release_s, prev);
    end
  endtask

  // Monitor: every strobe on either DUT must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_pulse) begin mon_evt(0, 1'b0); mon_excl(0, a_pulse, a_release, prev_pulse_a); end
      if (a_release) mon_evt(0, 1'b1);
      if (b_pulse) begin mon_evt(1, 1'b0); mon_excl(1, b_pulse, b_release, prev_pulse_b); end
      if (b_release) mon_evt(1, 1'b1);
      if (b_repeating) b_rep_seen = 1;
    end
    prev_pulse_a = a_pulse;
    prev_pulse_b = b_pulse;
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %b, required %b", name, cyc, act, exp);
    end
  endtask

  // Returns just after the rising edge that starts cycle c (no-op if already there).
  task automatic at_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic look(input int c);
    at_cycle(c);
    @(negedge clk);
  endtask

  initial begin
    int t;
    int r;
    logic [4:0] bounce;
    bit pressed_seen;

    rst   = 1'b1;
    btn_a = 1'b0;
    btn_b = 1'b0;

    look(3);
    chk("rst_a_pulse", a_pulse, 1'b0);
    chk("rst_a_pressed", a_pressed, 1'b0);
    chk("rst_a_release", a_release, 1'b0);
    chk("rst_a_repeating", a_repeating, 1'b0);
    chk("rst_b_pulse", b_pulse, 1'b0);
    chk("rst_b_pressed", b_pressed, 1'b0);
    at_cycle(4);
    rst = 1'b0;
    at_cycle(8);

    // Clean press held 40 cycles, then released.
    t = cyc;
    btn_a = 1'b1;
    push(0, 1'b0, t + 7);
    for (int k = 0; k < 9; k++) push(0, 1'b0, t + 17 + 3 * k);
    push(0, 1'b1, t + 47);
    look(t + 6);  chk("s1_pressed_before", a_pressed, 1'b0);
    look(t + 7);  chk("s1_pressed_after", a_pressed, 1'b1);
    look(t + 16); chk("s1_repeating_before", a_repeating, 1'b0);
    look(t + 17); chk("s1_repeating_after", a_repeating, 1'b1);
    at_cycle(t + 40);
    btn_a = 1'b0;
    look(t + 46); chk("s1_pressed_pre_release", a_pressed, 1'b1);
    look(t + 47); chk("s1_pressed_at_release", a_pressed, 1'b0);
    at_cycle(t + 55);

    // Bounce 1,0,1,1,0 then low: rejected, nothing emitted.
    t = cyc;
    bounce = 5'b01101;
    pressed_seen = 0;
    for (int i = 0; i < 5; i++) begin
      at_cycle(t + i);
      btn_a = bounce[i];
    end
    for (int c = 5; c < 16; c++) begin
      look(t + c);
      if (a_pressed) pressed_seen = 1;
    end
    chk("s2_bounce_pressed", pressed_seen, 1'b0);
    at_cycle(t + 20);

    // Press, 2-cycle drop during HELD (re-accepted), repeats, then real release.
    t = cyc;
    btn_a = 1'b1;
    push(0, 1'b0, t + 7);
    push(0, 1'b0, t + 24);
    push(0, 1'b0, t + 27);
    push(0, 1'b0, t + 30);
    push(0, 1'b1, t + 35);
    at_cycle(t + 8);  btn_a = 1'b0;
    at_cycle(t + 10); btn_a = 1'b1;
    look(t + 12); chk("s3_pressed_in_reldeb", a_pressed, 1'b1);
    look(t + 23); chk("s3_repeating_before", a_repeating, 1'b0);
    look(t + 24); chk("s3_repeating_after", a_repeating, 1'b1);
    at_cycle(t + 28); btn_a = 1'b0;
    look(t + 31); chk("s3_repeating_last", a_repeating, 1'b1);
    look(t + 32); chk("s3_repeating_off", a_repeating, 1'b0);
    look(t + 34); chk("s3_pressed_pre_release", a_pressed, 1'b1);
    look(t + 35); chk("s3_pressed_at_release", a_pressed, 1'b0);
    at_cycle(t + 45);

    // Reset pulsed mid-cycle during REPEAT with the button still held.
    t = cyc;
    btn_a = 1'b1;
    push(0, 1'b0, t + 7);
    push(0, 1'b0, t + 17);
    push(0, 1'b0, t + 20);
    look(t + 21); chk("s4_pressed_pre_reset", a_pressed, 1'b1);
    at_cycle(t + 21);
    #2;
    rst = 1'b1;
    #1;
    chk("s4_async_pulse", a_pulse, 1'b0);
    chk("s4_async_pressed", a_pressed, 1'b0);
    chk("s4_async_release", a_release, 1'b0);
    chk("s4_async_repeating", a_repeating, 1'b0);
    at_cycle(t + 23);
    rst = 1'b0;
    r = cyc;
    push(0, 1'b0, r + 7);
    push(0, 1'b1, r + 15);
    look(r + 6); chk("s4_pressed_redebounce", a_pressed, 1'b0);
    look(r + 7); chk("s4_pressed_after", a_pressed, 1'b1);
    at_cycle(r + 8);
    btn_a = 1'b0;
    at_cycle(r + 20);

    // Auto-repeat disabled: 100-cycle hold yields a single pulse.
    t = cyc;
    btn_b = 1'b1;
    push(1, 1'b0, t + 7);
    push(1, 1'b1, t + 107);
    look(t + 50); chk("s5_b_pressed_hold", b_pressed, 1'b1);
    at_cycle(t + 100);
    btn_b = 1'b0;
    at_cycle(t + 115);

    checks++;
    if (qa.size() != 0) begin
      failures++;
      $display("FAIL dut0 pending: %0d expected events never seen, required 0", qa.size());
    end
    checks++;
    if (qb.size() != 0) begin
      failures++;
      $display("FAIL dut1 pending: %0d expected events never seen, required 0", qb.size());
    end
    chk("s5_b_never_repeating", b_rep_seen, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
